// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and queues in-order
// responses for IF_ID. Defining IF_FETCH_PERF_EN adds the perf_fetched_o/perf_stall_o counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_stall_o
`endif
);
   localparam int            CW       = $clog2(FIFO_DEPTH + 1);
   localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

   logic [31:0]   r_pc;
   logic [31:0]   r_rsp_pc;
   logic [31:0]   r_fifo_instr [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;

   logic          w_req_fire;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [CW:0]   w_credit_used;
   logic [CW-1:0] w_outstanding_nxt;
   logic [31:0]   w_redirect_pc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Credits cover both in-flight requests and queued entries, so the FIFO can never overflow.
   assign w_redirect_pc     = {redirect_pc_i[31:2], 2'b00};
   assign w_credit_used     = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_empty           = (r_count == '0);
   assign w_full            = (r_count == CW'(FIFO_DEPTH));
   assign w_req_fire        = imem_req_valid_o && imem_req_ready_i;
   assign w_push            = imem_rsp_valid_i && (r_discard == '0) && !redirect_i;
   assign w_pop             = id_valid_o && id_ready_i;
   assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid_i);

   assign imem_req_valid_o  = !rst && !redirect_i && (w_credit_used < DEPTH_C);
   assign imem_req_addr_o   = r_pc;
   assign id_valid_o        = !w_empty && !redirect_i;
   assign id_instr_o        = w_empty ? '0 : r_fifo_instr[r_rd_ptr];
   assign id_pc_o           = w_empty ? '0 : r_fifo_pc[r_rd_ptr];

   // Control state: PC, FIFO pointers, credit and discard counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (redirect_i) begin
            r_pc      <= w_redirect_pc;
            r_rsp_pc  <= w_redirect_pc;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_discard <= w_outstanding_nxt;
         end else begin
            if (w_req_fire) r_pc <= r_pc + 32'd4;
            if (imem_rsp_valid_i && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + 32'd4;
               r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   // Response storage (data only, no reset)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_rsp_data_i;
         r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
         if (id_ready_i && !id_valid_o && !redirect_i) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_fetched_o = r_perf_fetched;
   assign perf_stall_o   = r_perf_stall;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop));
   a_counters:    assert property (@(posedge clk) disable iff (rst)
                     (r_discard <= r_outstanding) && ({1'b0, r_outstanding} <= DEPTH_C));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomised bench for if_fetch_stage: memory model with configurable latency,
// in-order PC scoreboard, and a second instance with RESET_PC at the top of the address space.
module tb_if_fetch_stage;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [31:0] id_instr, id_pc;

   logic        w_req_valid, w_id_valid;
   logic [31:0] w_req_addr, w_id_instr, w_id_pc;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .id_valid_o(id_valid), .id_ready_i(id_ready), .id_instr_o(id_instr), .id_pc_o(id_pc)
`ifdef IF_FETCH_PERF_EN
      , .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall)
`endif
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req_valid_o(w_req_valid), .imem_req_ready_i(1'b1), .imem_req_addr_o(w_req_addr),
      .imem_rsp_valid_i(1'b0), .imem_rsp_data_i(32'h0),
      .redirect_i(1'b0), .redirect_pc_i(32'h0),
      .id_valid_o(w_id_valid), .id_ready_i(1'b1), .id_instr_o(w_id_instr), .id_pc_o(w_id_pc)
`ifdef IF_FETCH_PERF_EN
      , .perf_fetched_o(w_perf_fetched), .perf_stall_o(w_perf_stall)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   mem_t        mem_q[$];
   int          cyc = 0;
   int          last_due = -1;
   int          lat_lo = 1, lat_hi = 1;
   int          n_cmp = 0, n_mis = 0;
   int          nfetched = 0, nstall = 0, nlive = 0, wrap_step = 0;
   logic [31:0] exp_pc, exp_req;
   logic        obs_req_fire, obs_id_fire, obs_req_valid, obs_id_valid;
   logic [31:0] obs_req_addr, obs_id_pc;

   logic [31:0] wrap_addr_tbl [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
   logic        wrap_vld_tbl  [3] = '{1'b1, 1'b1, 1'b0};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic observe();
      int due;
      obs_req_fire  = 1'b0;
      obs_id_fire   = 1'b0;
      obs_req_valid = req_valid;
      obs_req_addr  = req_addr;
      obs_id_valid  = id_valid;
      obs_id_pc     = id_pc;
      if (rst) begin
         check_eq("rst_req_valid", 32'(req_valid), 0);
         check_eq("rst_id_valid", 32'(id_valid), 0);
         check_eq("rst_id_instr", id_instr, 0);
         check_eq("rst_id_pc", id_pc, 0);
      end else begin
         nlive++;
         if (wrap_step < 3) begin
            check_eq("wrap_req_valid", 32'(w_req_valid), 32'(wrap_vld_tbl[wrap_step]));
            if (wrap_vld_tbl[wrap_step]) check_eq("wrap_req_addr", w_req_addr, wrap_addr_tbl[wrap_step]);
            wrap_step++;
         end
         if (redirect) begin
            check_eq("redir_id_valid", 32'(id_valid), 0);
            check_eq("redir_req_valid", 32'(req_valid), 0);
            exp_pc  = {redirect_pc[31:2], 2'b00};
            exp_req = exp_pc;
         end else begin
            if (req_valid && req_ready) begin
               check_eq("req_addr", req_addr, exp_req);
               exp_req += 32'd4;
               due = cyc + $urandom_range(lat_hi, lat_lo);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               mem_q.push_back('{req_addr, due});
               check_eq("inflight_le_depth", 32'(mem_q.size() <= DEPTH), 1);
               obs_req_fire = 1'b1;
            end
            if (id_valid && id_ready) begin
               check_eq("id_pc", id_pc, exp_pc);
               check_eq("id_instr", id_instr, ~exp_pc);
               exp_pc += 32'd4;
               nfetched++;
               obs_id_fire = 1'b1;
            end else if (!id_valid) begin
               check_eq("empty_instr", id_instr, 0);
               check_eq("empty_pc", id_pc, 0);
            end
            if (id_ready && !id_valid) nstall++;
         end
      end
   endtask

   task automatic drive_rsp();
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = ~mem_q[0].addr;
         void'(mem_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = 32'h0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      cyc++;
      #1;
      drive_rsp();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      step();
      redirect    = 1'b0;
      redirect_pc = 32'h0;
   endtask

   task automatic wait_id(input string tag, input logic [31:0] exp);
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (obs_id_fire) begin
            seen = 1'b1;
            check_eq(tag, obs_id_pc, exp);
         end
      end
      check_eq({tag, "_seen"}, 32'(seen), 1);
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp);
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (obs_req_fire) begin
            seen = 1'b1;
            check_eq(tag, obs_req_addr, exp);
         end
      end
      check_eq({tag, "_seen"}, 32'(seen), 1);
   endtask

   initial begin
      int fires;
      int k;
      rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
      exp_pc = 32'h0; exp_req = 32'h0;
      repeat (3) step();
      rst = 1'b0;

      // 1: first fetch and steady-state rate with a 1-cycle memory; the credit includes the
      // entry being popped, so depth 2 sustains two instructions every three cycles.
      fires = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i == 0) begin
            check_eq("t1_first_req_valid", 32'(obs_req_valid), 1);
            check_eq("t1_first_req_addr", obs_req_addr, 32'h0);
         end
         if (i < 2) check_eq("t1_no_id_yet", 32'(obs_id_valid), 0);
         if (i == 2) begin
            check_eq("t1_first_id_valid", 32'(obs_id_valid), 1);
            check_eq("t1_first_id_pc", obs_id_pc, 32'h0);
         end
         if (i >= 3) fires += int'(obs_id_fire);
      end
      check_eq("t1_throughput", fires, 8);

      // 2: stall right after a redirect: exactly DEPTH requests, then request valid drops
      id_ready = 1'b0;
      do_redirect(32'h40);
      fires = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         fires += int'(obs_req_fire);
      end
      check_eq("t2_stall_reqs", fires, DEPTH);
      check_eq("t2_req_stopped", 32'(obs_req_valid), 0);
      check_eq("t2_id_pending", 32'(obs_id_valid), 1);
      id_ready = 1'b1;
      wait_id("t2_resume_pc", 32'h40);
      repeat (8) step();

      // 3: redirect with two requests in flight
      lat_lo = 3; lat_hi = 3;
      k = 0;
      while (!(mem_q.size() == 2 && !rsp_valid) && k < 40) begin
         step();
         k++;
      end
      check_eq("t3_two_inflight", mem_q.size(), 2);
      do_redirect(32'h100);
      wait_id("t3_pc0", 32'h100);
      wait_id("t3_pc1", 32'h104);

      // 4: redirect in the same cycle as a response with id_ready high
      lat_lo = 1; lat_hi = 1;
      k = 0;
      while (!rsp_valid && k < 20) begin
         step();
         k++;
      end
      check_eq("t4_rsp_present", 32'(rsp_valid), 1);
      do_redirect(32'h300);
      wait_id("t4_first_pc", 32'h300);

      // 5: misaligned redirect and PC wrap
      do_redirect(32'h203);
      wait_req("t5_aligned_req", 32'h200);
      wait_id("t5_aligned_id", 32'h200);
      do_redirect(32'hFFFF_FFF8);
      wait_req("t5_req_top", 32'hFFFF_FFF8);
      wait_req("t5_req_last", 32'hFFFF_FFFC);
      wait_req("t5_req_wrap", 32'h0);
      repeat (6) step();

      // 6: random latency, back-pressure and redirects
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 400; i++) begin
         req_ready = ($urandom_range(3, 0) != 0);
         id_ready  = ($urandom_range(3, 0) != 0);
         if ($urandom_range(29, 0) == 0) begin
            redirect    = 1'b1;
            redirect_pc = $urandom & 32'h0000_0FFF;
         end
         step();
         redirect    = 1'b0;
         redirect_pc = 32'h0;
      end
      req_ready = 1'b1;
      id_ready  = 1'b1;
      repeat (20) step();
      check_eq("t6_progress", 32'(nfetched > 150), 1);

      check_eq("wrap_id_valid", 32'(w_id_valid), 0);
      check_eq("wrap_id_instr", w_id_instr, 0);
      check_eq("wrap_id_pc", w_id_pc, 0);
`ifdef IF_FETCH_PERF_EN
      check_eq("perf_fetched", perf_fetched, nfetched);
      check_eq("perf_stall", perf_stall, nstall);
      check_eq("wrap_perf_fetched", w_perf_fetched, 0);
      check_eq("wrap_perf_stall", w_perf_stall, nlive);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
